cart_ram_backup: RTL and testbench
==================================

// Module: cart_ram_backup
// PURPOSE
// Save-RAM backup engine: streams cartridge RAM to/from external storage in 512-byte sectors.
// Drives the cart-RAM second port (bk_*) as reader (save) or writer (load), while the MBC
// drives port A from the CPU side. Sits between the cart RAM dpram and the SD/storage agent.
// Supports battery-backed MBC carts only; tracks dirty state for auto-save on menu open.
// PARAMETERS
// LBA_W     8   width of sector counter output bits used for RAM addressing (256 sectors max)
// SECT_AW   9   byte address width inside a sector (512 bytes)
// PORTS
// clk_sys        in   1   system clock
// reset          in   1   synchronous, active-high
// cart_mbc_type  in   8   cartridge header 0x147
// cart_ram_size  in   8   cartridge header 0x149
// cart_download  in   1   high while cartridge image is being downloaded
// img_mounted    in   1   save image mount strobe
// img_readonly   in   1   mounted save image is read-only
// img_size_nz    in   1   mounted save image size is non-zero
// load_req       in   1   manual load trigger (rising edge)
// save_req       in   1   manual save trigger (rising edge)
// autosave_en    in   1   enable auto-save when osd_status rises
// osd_status     in   1   on-screen menu open
// cram_wr        in   1   CPU write strobe into cart RAM (from MBC)
// sd_lba         out  32  sector number; upper bits zero
// sd_rd, sd_wr   out  1   sector read/write request to storage agent
// sd_ack         in   1   storage agent busy with current sector
// sd_buff_addr   in   9   byte index within sector
// sd_buff_dout   in   8   load data from storage
// sd_buff_wr     in   1   load data strobe
// sd_buff_din    out  8   save data to storage (= bk_q)
// bk_addr        out  17  cart RAM port B address = {sd_lba[7:0], sd_buff_addr}
// bk_wr          out  1   cart RAM port B write
// bk_data        out  8   cart RAM port B write data (= sd_buff_dout)
// bk_q           in   8   cart RAM port B read data, 1-cycle read latency
// busy, loading  out  1   transfer in progress; direction of transfer
// BEHAVIOUR
// - Reset: sd_lba=0, sd_rd=0, sd_wr=0, bk_wr=0, busy=0, loading=0, bk_ena=0, dirty=0, state IDLE.
// - supported = battery type (0x03,06,09,0D,10,13,1B,1E,22,FF) & (ram_size>0 | MBC2 type 5/6) & bk_ena.
// - bk_ena: cleared on cart_download rise; set by img_mounted & ~img_readonly while cart_download=1.
// - last_lba: MBC2 0; ram_size 1 ->3; 2 ->15; 3 ->63; >=4 ->255.
// - Triggers (IDLE only, else ignored): auto-load on cart_download fall if bk_ena & img_size_nz;
//   load_req rise; save_req rise; autosave = osd_status rise & dirty & autosave_en. Load wins ties.
//   Manual triggers need supported; auto-load needs bk_ena.
// - FSM IDLE -> REQ: busy=1, loading set, sd_lba=0, sd_rd=loading, sd_wr=~loading.
//   REQ -> XFER on sd_ack rise: sd_rd/sd_wr drop same cycle. XFER -> on sd_ack fall:
//   sd_lba[7:0]>=last_lba -> IDLE (busy=0, loading=0); else sd_lba+1, reassert request, REQ.
// - bk_wr = sd_buff_wr & sd_ack & loading (combinational); no port-B writes when saving.
// - sd_buff_din = bk_q; agent samples it one cycle after sd_buff_addr changes.
// - dirty: set on cram_wr & supported & ~osd_status; cleared when a save leaves IDLE;
//   set in same cycle as save start -> dirty stays 1. Load completion clears dirty.
// - Reset mid-transfer aborts immediately to reset values; storage agent must tolerate dropped request.
// STRUCTURE
// - Shared package gb_cart_pkg: battery-type constant list, ram_size->last_lba function,
//   MBC2 type test, state enum {IDLE, REQ, XFER}.
// - One sub-module: edge_det (registered rise/fall detector) instanced for load_req, save_req,
//   osd_status, cart_download, sd_ack. Everything else stays flat.
// TESTING
// - type 0x03, ram_size 2, mount rw during download, download falls -> 16 sectors read, lba 0..15, busy low after 16th ack fall.
// - load: sd_buff_wr with addr 0x1FF, dout 0xA5 at lba 3 -> bk_addr 0x007FF, bk_wr=1, bk_data 0xA5.
// - save type 0x06: one sector, sd_wr only, sd_buff_din equals bk_q of bk_addr {0,addr} one cycle later.
// - cram_wr then osd_status rise, autosave_en=1 -> save starts, dirty clears; autosave_en=0 -> nothing.
// - type 0x01 (no battery) save_req -> no request; load_req+save_req same cycle -> sd_rd only.
// - reset asserted in XFER at lba 5 -> next cycle all outputs zero, IDLE; new save_req ignored until bk_ena re-set.

Source files
------------

// File: rtl/cart_ram_backup_pkg.sv
// Shared definitions for the cart RAM backup engine: sector geometry,
// transfer states and helpers that decode the cartridge header.
package cart_ram_backup_pkg;

    localparam int LBA_W   = 8;
    localparam int SECT_AW = 9;
    localparam int BK_AW   = LBA_W + SECT_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } xfer_state_t;

    // Header types whose RAM is battery backed and therefore worth saving.
    function automatic logic is_battery(input logic [7:0] mbcType);
        logic hit;
        hit = 1'b0;
        case (mbcType)
            8'h03, 8'h06, 8'h09, 8'h0D, 8'h10,
            8'h13, 8'h1B, 8'h1E, 8'h22, 8'hFF: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // MBC2 carries its own 512x4 RAM and reports a RAM size of zero.
    function automatic logic is_mbc2(input logic [7:0] mbcType);
        return (mbcType == 8'h05) || (mbcType == 8'h06);
    endfunction

    // Index of the final 512-byte sector that holds cart RAM contents.
    function automatic logic [LBA_W-1:0] last_lba_f(input logic [7:0] ramSize,
                                                    input logic       mbc2);
        logic [LBA_W-1:0] last;
        if (mbc2) begin
            last = '0;
        end else begin
            case (ramSize)
                8'd0:    last = LBA_W'(0);
                8'd1:    last = LBA_W'(3);
                8'd2:    last = LBA_W'(15);
                8'd3:    last = LBA_W'(63);
                default: last = LBA_W'(255);
            endcase
        end
        return last;
    endfunction

endpackage

// File: rtl/cart_ram_backup_if.sv
// Storage-agent and cart-RAM port B signals used by the backup engine.
// The engine is the master; the storage agent / dpram side is the slave.
interface cart_ram_backup_if;
    import cart_ram_backup_pkg::*;

    logic [31:0]      sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;
    logic [SECT_AW-1:0] sd_buff_addr;
    logic [7:0]       sd_buff_dout;
    logic             sd_buff_wr;
    logic [7:0]       sd_buff_din;
    logic [BK_AW-1:0] bk_addr;
    logic             bk_wr;
    logic [7:0]       bk_data;
    logic [7:0]       bk_q;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, bk_addr, bk_wr, bk_data,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, bk_q
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, bk_addr, bk_wr, bk_data,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, bk_q
    );

endinterface

// File: rtl/cart_ram_backup_edge_det.sv
// Rise/fall detector against the previous-cycle value of a level input.
module cart_ram_backup_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    // Remember last cycle's level so the current level can be compared to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;
    assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/cart_ram_backup.sv
// Save-RAM backup engine: moves battery-backed cart RAM to and from
// external storage one 512-byte sector at a time over cart RAM port B.
module cart_ram_backup
    import cart_ram_backup_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] cart_mbc_type_i,
    input  logic [7:0] cart_ram_size_i,
    input  logic       cart_download_i,
    input  logic       img_mounted_i,
    input  logic       img_readonly_i,
    input  logic       img_size_nz_i,
    input  logic       load_req_i,
    input  logic       save_req_i,
    input  logic       autosave_en_i,
    input  logic       osd_status_i,
    input  logic       cram_wr_i,
    output logic       busy_o,
    output logic       loading_o,
    output logic       dirty_o,
    cart_ram_backup_if.master bus
);

    xfer_state_t      state_q, state_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic             sdRd_q, sdRd_d;
    logic             sdWr_q, sdWr_d;
    logic             busy_q, busy_d;
    logic             loading_q, loading_d;
    logic             dirty_q, dirty_d;
    logic             bkEna_q;

    logic loadReqRise, loadReqFall;
    logic saveReqRise, saveReqFall;
    logic osdRise, osdFall;
    logic downloadRise, downloadFall;
    logic ackRise, ackFall;
    logic unusedEdges;

    logic             mbc2;
    logic             supported;
    logic [LBA_W-1:0] lastLba;
    logic             loadTrig;
    logic             saveTrig;
    logic             dirtySet;
    logic             saveStart;
    logic             loadDone;

    cart_ram_backup_edge_det loadReqEdge (.clk(clk_sys), .reset(reset), .sig_i(load_req_i),
                                          .rise_o(loadReqRise), .fall_o(loadReqFall));
    cart_ram_backup_edge_det saveReqEdge (.clk(clk_sys), .reset(reset), .sig_i(save_req_i),
                                          .rise_o(saveReqRise), .fall_o(saveReqFall));
    cart_ram_backup_edge_det osdEdge     (.clk(clk_sys), .reset(reset), .sig_i(osd_status_i),
                                          .rise_o(osdRise), .fall_o(osdFall));
    cart_ram_backup_edge_det downloadEdge(.clk(clk_sys), .reset(reset), .sig_i(cart_download_i),
                                          .rise_o(downloadRise), .fall_o(downloadFall));
    cart_ram_backup_edge_det ackEdge     (.clk(clk_sys), .reset(reset), .sig_i(bus.sd_ack),
                                          .rise_o(ackRise), .fall_o(ackFall));

    assign unusedEdges = loadReqFall | saveReqFall | osdFall;

    assign mbc2      = is_mbc2(cart_mbc_type_i);
    assign supported = is_battery(cart_mbc_type_i)
                     & ((cart_ram_size_i != 8'd0) | mbc2) & bkEna_q;
    assign lastLba   = last_lba_f(cart_ram_size_i, mbc2);
    assign loadTrig  = (downloadFall & bkEna_q & img_size_nz_i) | (loadReqRise & supported);
    assign saveTrig  = (saveReqRise & supported) | (osdRise & dirty_q & autosave_en_i);
    assign dirtySet  = cram_wr_i & supported & ~osd_status_i;

    // A new download invalidates the backup image until a writable save image is mounted.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bkEna_q <= 1'b0;
        end else if (downloadRise) begin
            bkEna_q <= 1'b0;
        end else if (cart_download_i & img_mounted_i & ~img_readonly_i) begin
            bkEna_q <= 1'b1;
        end
    end

    // Transfer state and request registers; reset drops any transfer in flight.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            lba_q     <= '0;
            sdRd_q    <= 1'b0;
            sdWr_q    <= 1'b0;
            busy_q    <= 1'b0;
            loading_q <= 1'b0;
            dirty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lba_q     <= lba_d;
            sdRd_q    <= sdRd_d;
            sdWr_q    <= sdWr_d;
            busy_q    <= busy_d;
            loading_q <= loading_d;
            dirty_q   <= dirty_d;
        end
    end

    // Sector sequencing: request, wait for the agent to take it, advance on its release.
    always_comb begin
        state_d   = state_q;
        lba_d     = lba_q;
        sdRd_d    = sdRd_q;
        sdWr_d    = sdWr_q;
        busy_d    = busy_q;
        loading_d = loading_q;
        saveStart = 1'b0;
        loadDone  = 1'b0;

        case (state_q)
            IDLE: begin
                if (loadTrig) begin
                    state_d   = REQ;
                    busy_d    = 1'b1;
                    loading_d = 1'b1;
                    lba_d     = '0;
                    sdRd_d    = 1'b1;
                    sdWr_d    = 1'b0;
                end else if (saveTrig) begin
                    state_d   = REQ;
                    busy_d    = 1'b1;
                    loading_d = 1'b0;
                    lba_d     = '0;
                    sdRd_d    = 1'b0;
                    sdWr_d    = 1'b1;
                    saveStart = 1'b1;
                end
            end
            REQ: begin
                if (ackRise) begin
                    state_d = XFER;
                    sdRd_d  = 1'b0;
                    sdWr_d  = 1'b0;
                end
            end
            XFER: begin
                if (ackFall) begin
                    if (lba_q >= lastLba) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        loadDone  = loading_q;
                    end else begin
                        state_d = REQ;
                        lba_d   = lba_q + LBA_W'(1);
                        sdRd_d  = loading_q;
                        sdWr_d  = ~loading_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        dirty_d = dirty_q;
        if (saveStart) dirty_d = 1'b0;
        if (dirtySet)  dirty_d = 1'b1;
        if (loadDone)  dirty_d = 1'b0;
    end

    assign bus.sd_lba      = {{(32 - LBA_W){1'b0}}, lba_q};
    assign bus.sd_rd       = sdRd_q;
    assign bus.sd_wr       = sdWr_q;
    assign bus.sd_buff_din = bus.bk_q;
    assign bus.bk_addr     = {lba_q, bus.sd_buff_addr};
    assign bus.bk_wr       = bus.sd_buff_wr & bus.sd_ack & loading_q;
    assign bus.bk_data     = bus.sd_buff_dout;
    assign busy_o          = busy_q;
    assign loading_o       = loading_q;
    assign dirty_o         = dirty_q;

endmodule

// File: tb/tb_cart_ram_backup.sv
// Bench for cart_ram_backup: plays the storage agent and the cart RAM,
// checks sector sequences and data against a pattern model, and checks
// the port-B/storage rules on every cycle.
module tb_cart_ram_backup;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] cart_mbc_type;
    logic [7:0] cart_ram_size;
    logic       cart_download;
    logic       img_mounted;
    logic       img_readonly;
    logic       img_size_nz;
    logic       load_req;
    logic       save_req;
    logic       autosave_en;
    logic       osd_status;
    logic       cram_wr;
    logic       busy_o;
    logic       loading_o;
    logic       dirty_o;

    int nChecks   = 0;
    int nFails    = 0;
    int ramWrites = 0;
    bit checkEn   = 1'b0;

    logic [7:0] ram [0:131071];

    always #5 clk_sys = ~clk_sys;

    cart_ram_backup_if busIf();

    cart_ram_backup dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .cart_mbc_type_i(cart_mbc_type),
        .cart_ram_size_i(cart_ram_size),
        .cart_download_i(cart_download),
        .img_mounted_i  (img_mounted),
        .img_readonly_i (img_readonly),
        .img_size_nz_i  (img_size_nz),
        .load_req_i     (load_req),
        .save_req_i     (save_req),
        .autosave_en_i  (autosave_en),
        .osd_status_i   (osd_status),
        .cram_wr_i      (cram_wr),
        .busy_o         (busy_o),
        .loading_o      (loading_o),
        .dirty_o        (dirty_o),
        .bus            (busIf)
    );

    // Cart RAM port B: one-cycle read latency, writes counted to catch stray sectors.
    always @(posedge clk_sys) begin
        if (busIf.bk_wr) begin
            ram[busIf.bk_addr] <= busIf.bk_data;
            ramWrites <= ramWrites + 1;
        end
        busIf.bk_q <= ram[busIf.bk_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Storage-side data pattern for byte i of sector l; one byte is a marked value.
    function automatic logic [7:0] pat(input int l, input int i);
        if (l == 3 && i == 511) return 8'hA5;
        return 8'((l * 37 + i * 7 + 90) % 256);
    endfunction

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic applyStimulus(input bit ld, input bit sv, input bit cw);
        load_req = ld;
        save_req = sv;
        cram_wr  = cw;
        tick();
        load_req = 1'b0;
        save_req = 1'b0;
        cram_wr  = 1'b0;
    endtask

    task automatic expectQuiet(input int n, input string name);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            seen = seen | busIf.sd_rd | busIf.sd_wr | busy_o;
        end
        checkOutput(name, 32'(seen), 32'd0);
    endtask

    task automatic waitReq(input bit ld, input int s);
        int n;
        n = 0;
        while (!(busIf.sd_rd || busIf.sd_wr) && n < 40) begin
            tick();
            n++;
        end
        checkOutput("requestSeen", 32'(busIf.sd_rd | busIf.sd_wr), 32'd1);
        checkOutput("reqRead", 32'(busIf.sd_rd), 32'(ld));
        checkOutput("reqWrite", 32'(busIf.sd_wr), 32'(!ld));
        checkOutput("reqLba", busIf.sd_lba, 32'(s));
        checkOutput("reqBusy", 32'(busy_o), 32'd1);
        checkOutput("reqLoading", 32'(loading_o), 32'(ld));
    endtask

    task automatic doSector(input bit ld, input int s, input bit last);
        waitReq(ld, s);
        busIf.sd_ack = 1'b1;
        tick();
        checkOutput("reqDropOnAck", 32'({busIf.sd_rd, busIf.sd_wr}), 32'd0);
        for (int i = 0; i < 512; i++) begin
            busIf.sd_buff_addr = 9'(i);
            if (ld) begin
                busIf.sd_buff_dout = pat(s, i);
                busIf.sd_buff_wr   = 1'b1;
                if (s == 3 && i == 511) begin
                    #1;
                    checkOutput("litBkAddr", 32'(busIf.bk_addr), 32'h0000_07FF);
                    checkOutput("litBkWr", 32'(busIf.bk_wr), 32'd1);
                    checkOutput("litBkData", 32'(busIf.bk_data), 32'h0000_00A5);
                end
                tick();
            end else begin
                tick();
                checkOutput("saveData", 32'(busIf.sd_buff_din), 32'(pat(s, i)));
            end
        end
        busIf.sd_buff_wr = 1'b0;
        busIf.sd_ack     = 1'b0;
        tick();
        if (last) begin
            checkOutput("endBusy", 32'(busy_o), 32'd0);
            checkOutput("endLoading", 32'(loading_o), 32'd0);
            checkOutput("endNoReq", 32'({busIf.sd_rd, busIf.sd_wr}), 32'd0);
        end
    endtask

    // Port-B and request rules that must hold on every cycle.
    always @(negedge clk_sys) begin
        if (checkEn) begin
            checkOutput("bkAddrMap", 32'(busIf.bk_addr), 32'({busIf.sd_lba[7:0], busIf.sd_buff_addr}));
            checkOutput("bkWrRule", 32'(busIf.bk_wr), 32'(busIf.sd_buff_wr & busIf.sd_ack & loading_o));
            checkOutput("bkDataPass", 32'(busIf.bk_data), 32'(busIf.sd_buff_dout));
            checkOutput("buffDinPass", 32'(busIf.sd_buff_din), 32'(busIf.bk_q));
            checkOutput("lbaUpperZero", 32'(busIf.sd_lba[31:8]), 32'd0);
            checkOutput("reqDirection", 32'((busIf.sd_rd & ~loading_o) | (busIf.sd_wr & loading_o)
                        | ((busIf.sd_rd | busIf.sd_wr) & ~busy_o) | (busIf.sd_rd & busIf.sd_wr)), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h02;
        cart_download = 1'b0;
        img_mounted = 1'b0;
        img_readonly = 1'b0;
        img_size_nz = 1'b0;
        load_req = 1'b0;
        save_req = 1'b0;
        autosave_en = 1'b0;
        osd_status = 1'b0;
        cram_wr = 1'b0;
        busIf.sd_ack = 1'b0;
        busIf.sd_buff_addr = '0;
        busIf.sd_buff_dout = '0;
        busIf.sd_buff_wr = 1'b0;

        // reset values
        repeat (3) tick();
        checkEn = 1'b1;
        checkOutput("rstLba", busIf.sd_lba, 32'd0);
        checkOutput("rstRdWr", 32'({busIf.sd_rd, busIf.sd_wr}), 32'd0);
        checkOutput("rstBkWr", 32'(busIf.bk_wr), 32'd0);
        checkOutput("rstBusyLoad", 32'({busy_o, loading_o}), 32'd0);
        checkOutput("rstDirty", 32'(dirty_o), 32'd0);
        reset = 1'b0;
        tick();

        // auto-load after download with a writable, non-empty image: 16 sectors
        cart_download = 1'b1;
        tick();
        img_mounted = 1'b1;
        img_size_nz = 1'b1;
        tick();
        img_mounted = 1'b0;
        tick();
        cart_download = 1'b0;
        tick();
        for (int s = 0; s < 16; s++) doSector(1'b1, s, s == 15);
        checkOutput("loadWrites", 32'(ramWrites), 32'd8192);
        checkOutput("ramSect0", 32'(ram[17'h00000]), 32'h0000_005A);
        checkOutput("ramSect15", 32'(ram[17'h01E00]), 32'h0000_0085);
        checkOutput("ramMarked", 32'(ram[17'h007FF]), 32'h0000_00A5);
        checkOutput("ramModel", 32'(ram[17'h00C64]), 32'(pat(6, 100)));
        checkOutput("loadDirty", 32'(dirty_o), 32'd0);

        // manual save of an MBC2 cart: one sector, write requests only
        cart_mbc_type = 8'h06;
        cart_ram_size = 8'h00;
        applyStimulus(1'b0, 1'b1, 1'b0);
        doSector(1'b0, 0, 1'b1);

        // CPU write marks dirty; menu open without autosave does nothing
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("dirtySet", 32'(dirty_o), 32'd1);
        osd_status = 1'b1;
        expectQuiet(4, "noAutosaveDisabled");
        osd_status = 1'b0;
        tick();

        // menu open with autosave enabled starts a save and clears dirty
        autosave_en = 1'b1;
        osd_status = 1'b1;
        tick();
        osd_status = 1'b0;
        checkOutput("autosaveBusy", 32'(busy_o), 32'd1);
        checkOutput("autosaveDirtyClr", 32'(dirty_o), 32'd0);
        doSector(1'b0, 0, 1'b1);
        autosave_en = 1'b0;

        // write in the same cycle as a save start keeps dirty set
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("dirtyKeptOnStart", 32'(dirty_o), 32'd1);
        doSector(1'b0, 0, 1'b1);

        // cart without battery ignores both manual triggers
        cart_mbc_type = 8'h01;
        cart_ram_size = 8'h02;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectQuiet(4, "noSaveNoBattery");
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectQuiet(4, "noLoadNoBattery");

        // simultaneous load and save: load wins; load completion clears dirty
        cart_mbc_type = 8'h06;
        cart_ram_size = 8'h00;
        applyStimulus(1'b1, 1'b1, 1'b0);
        doSector(1'b1, 0, 1'b1);
        checkOutput("loadClearsDirty", 32'(dirty_o), 32'd0);

        // reset while transferring sector 5 aborts the load
        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h02;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) doSector(1'b1, s, 1'b0);
        waitReq(1'b1, 5);
        busIf.sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            busIf.sd_buff_addr = 9'(i);
            busIf.sd_buff_dout = pat(5, i);
            busIf.sd_buff_wr = 1'b1;
            tick();
        end
        checkOutput("abortLba", busIf.sd_lba, 32'd5);
        busIf.sd_buff_wr = 1'b0;
        busIf.sd_ack = 1'b0;
        reset = 1'b1;
        tick();
        checkOutput("abortLbaZero", busIf.sd_lba, 32'd0);
        checkOutput("abortRdWr", 32'({busIf.sd_rd, busIf.sd_wr}), 32'd0);
        checkOutput("abortBusyLoad", 32'({busy_o, loading_o}), 32'd0);
        checkOutput("abortBkWr", 32'(busIf.bk_wr), 32'd0);
        reset = 1'b0;
        tick();

        // backup disabled after reset until a writable image is mounted again
        cart_mbc_type = 8'h06;
        cart_ram_size = 8'h00;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectQuiet(4, "noSaveAfterReset");
        img_size_nz = 1'b0;
        cart_download = 1'b1;
        tick();
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        cart_download = 1'b0;
        expectQuiet(3, "noAutoLoadEmptyImage");
        applyStimulus(1'b0, 1'b1, 1'b0);
        doSector(1'b0, 0, 1'b1);

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
